iomem_dma: RTL and testbench
============================

# iomem_dma

Word-copy bus initiator for the PicoSoC iomem bus. It takes a copy command, then issues its own PicoRV32-native read/write transactions on an iomem-style port: read a word from a source address, write it to a destination address, repeat. The typical use is draining the RNG data register at 0x0300_1000 into user RAM at 0x0300_20xx without CPU involvement. It sits on the master side of the iomem bus, facing the same responders the SoC top decodes (GPIO, RNG, user RAM).

## Interface
Parameters:
- LEN_BITS, 16, width of word-count field.
- TIMEOUT, 64, max cycles to wait for mem_ready per transaction; 0 disables timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid && cmd_ready.
- cmd_src  in  32  source byte address (word aligned; bits [1:0] forced to 0 internally).
- cmd_dst  in  32  destination byte address (same alignment rule).
- cmd_len  in  LEN_BITS  number of words to copy.
- cmd_src_inc  in  1  1: src += 4 per word; 0: src fixed (FIFO/register source).
- cmd_dst_inc  in  1  1: dst += 4 per word; 0: dst fixed.
- mem_valid  out  1  transaction request.
- mem_ready  in  1  responder completion strobe.
- mem_wstrb  out  4  0000 = read, 1111 = write.
- mem_addr  out  32  transaction address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, sampled in the cycle mem_ready=1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on command completion (normal or error).
- error  out  1  set on timeout; held until next command accepted.
- words_done  out  LEN_BITS  words fully written for current/last command.

## Operation
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE: cmd_ready=1, mem_valid=0. On accept: latch src/dst/len/inc flags, clear error and words_done. If cmd_len==0, go to FIN; else go to RD.
- RD: mem_valid=1, mem_wstrb=0000, mem_addr=src. On mem_ready: latch mem_rdata into data register, go to RD_GAP.
- RD_GAP: mem_valid=0 for exactly one cycle, then WR. This guarantees the responder sees valid low after its ready pulse.
- WR: mem_valid=1, mem_wstrb=1111, mem_addr=dst, mem_wdata=data register. On mem_ready:
  - words_done += 1.
  - src += 4 if src_inc.
  - dst += 4 if dst_inc.
  - Go to WR_GAP.
- WR_GAP: mem_valid=0 for one cycle. Go to FIN if words_done==len, else RD.
- FIN: done=1 for this cycle only, busy=1, then IDLE.
- mem_addr, mem_wstrb and mem_wdata are held stable while mem_valid=1, until mem_ready is sampled.
- Address increment wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- Timeout:
  - In RD/WR, a wait counter counts cycles with mem_ready=0 and clears on entry to RD/WR.
  - When the count reaches TIMEOUT: drop mem_valid, set error=1, go to FIN. words_done is left at its current value.
- cmd_valid while busy is ignored (cmd_ready=0); no queuing.
- mem_ready while mem_valid=0 is ignored.

## Timing
- Reset values: state=IDLE, cmd_ready=1, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_done=0.
- Reset mid-transfer: mem_valid is low from the first clock edge with resetn=0. No partial write completes after that edge.
- Command accepted at edge T:
  - mem_valid=1 (read) in cycle T+1.
  - With a responder that asserts ready the cycle after valid (as the SoC iomem decoder does), each word costs 6 cycles: RD, ready, RD_GAP, WR, ready, WR_GAP.
- For an N-word copy with a 1-cycle responder, done pulses at T+1+6N; busy falls in the following cycle.
- cmd_len=0: FIN at T+1, done pulse at T+1, no mem_valid ever.
- All outputs are registered.

## Test plan
- len=1, src=0x0300_1000 (responder returns 0xDEAD_BEEF), dst=0x0300_2000, inc=1/1 -> one read with wstrb=0000 at 0x0300_1000, then one write with wstrb=1111 and wdata=0xDEAD_BEEF at 0x0300_2000; done pulse 7 cycles after accept; words_done=1; error=0.
- len=4, src_inc=0, dst_inc=1, dst=0x0300_2000, responder returns 1,2,3,4 -> all reads at 0x0300_1000; writes of 1,2,3,4 to 0x2000,0x2004,0x2008,0x200C; mem_valid low exactly one cycle between every transaction.
- Responder stalls ready for 10 cycles on the second read -> addr/wstrb stable throughout the stall; copy completes correctly; done 10 cycles later than the unstalled case.
- TIMEOUT=64, responder never asserts ready on the first write -> mem_valid drops after 64 cycles; error=1; done pulse; words_done=0; next accepted command clears error.
- dst=0xFFFF_FFFC, len=2, dst_inc=1 -> writes at 0xFFFF_FFFC then 0x0000_0000.
- len=0 -> done at T+1, no bus activity. Separately: resetn low mid-WR -> mem_valid=0, busy=0, cmd_ready=1 the next cycle.

Source files
------------

// File: rtl/iomem_dma_if.sv
// iomem-style bus between the copy engine and its responders.
// Native PicoRV32 signalling: wstrb 0 = read, 4'hF = write.
interface iomem_dma_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_wstrb,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_wstrb,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/iomem_dma.sv
// Word-copy bus initiator on the iomem bus: read src, write dst, repeat.
// Every output is a register loaded from the next-state decode.
module iomem_dma #(
  parameter int LEN_BITS = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_src,
  input  logic [31:0]         cmd_dst,
  input  logic [LEN_BITS-1:0] cmd_len,
  input  logic                cmd_src_inc,
  input  logic                cmd_dst_inc,
  iomem_dma_if.master         mem,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_BITS-1:0] words_done
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST =
    WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, RD, RD_GAP, WR, WR_GAP, FIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [31:0]         src, src_n;
  logic [31:0]         dst, dst_n;
  logic [LEN_BITS-1:0] len, len_n;
  logic                src_inc, sinc_n;
  logic                dst_inc, dinc_n;
  logic [WW-1:0]       wait_cnt, wait_n;
  logic [LEN_BITS-1:0] words_n;
  logic                err_n;
  logic [31:0]         addr_n;
  logic [31:0]         wdata_n;
  logic                on_bus;
  logic                tmo;

  assign on_bus = (state == RD) || (state == WR);

  // wait_cnt counts ready-less cycles; the last allowed one ends the wait
  assign tmo = (TIMEOUT != 0) && on_bus &&
               !mem.mem_ready && (wait_cnt == WLAST);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid)
          state_n = (cmd_len == '0) ? FIN : RD;
      end
      RD: begin
        if (mem.mem_ready) state_n = RD_GAP;
        else if (tmo)      state_n = FIN;
      end
      RD_GAP: state_n = WR;
      WR: begin
        if (mem.mem_ready) state_n = WR_GAP;
        else if (tmo)      state_n = FIN;
      end
      WR_GAP: begin
        state_n = (words_done == len) ? FIN : RD;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    src_n   = src;
    dst_n   = dst;
    len_n   = len;
    sinc_n  = src_inc;
    dinc_n  = dst_inc;
    wait_n  = '0;
    words_n = words_done;
    err_n   = error;
    wdata_n = mem.mem_wdata;
    addr_n  = mem.mem_addr;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          src_n   = cmd_src & ~32'h3;
          dst_n   = cmd_dst & ~32'h3;
          len_n   = cmd_len;
          sinc_n  = cmd_src_inc;
          dinc_n  = cmd_dst_inc;
          words_n = '0;
          err_n   = 1'b0;
        end
      end
      RD: begin
        if (mem.mem_ready) wdata_n = mem.mem_rdata;
      end
      WR: begin
        if (mem.mem_ready) begin
          words_n = words_done + LEN_BITS'(1);
          if (src_inc) src_n = src + 32'd4;
          if (dst_inc) dst_n = dst + 32'd4;
        end
      end
      default: ;
    endcase
    if (tmo) err_n = 1'b1;
    if (on_bus && (state_n == state))
      wait_n = wait_cnt + WW'(1);
    if (state_n == RD)      addr_n = src_n;
    else if (state_n == WR) addr_n = dst_n;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      src            <= '0;
      dst            <= '0;
      len            <= '0;
      src_inc        <= 1'b0;
      dst_inc        <= 1'b0;
      wait_cnt       <= '0;
      words_done     <= '0;
      error          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cmd_ready      <= 1'b1;
      mem.mem_valid  <= 1'b0;
      mem.mem_wstrb  <= 4'h0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
    end else begin
      src            <= src_n;
      dst            <= dst_n;
      len            <= len_n;
      src_inc        <= sinc_n;
      dst_inc        <= dinc_n;
      wait_cnt       <= wait_n;
      words_done     <= words_n;
      error          <= err_n;
      busy           <= (state_n != IDLE);
      done           <= (state_n == FIN);
      cmd_ready      <= (state_n == IDLE);
      mem.mem_valid  <= (state_n == RD) || (state_n == WR);
      mem.mem_wstrb  <= (state_n == WR) ? 4'hF : 4'h0;
      mem.mem_addr   <= addr_n;
      mem.mem_wdata  <= wdata_n;
    end
  end

endmodule

// File: tb/tb_iomem_dma.sv
// Directed bench for iomem_dma with a latency-programmable responder.
// Cycle numbering: accept cycle is 1, so an N-word copy pulses done at 1+6N.
module tb_iomem_dma;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src;
  logic [31:0] cmd_dst;
  logic [15:0] cmd_len;
  logic        cmd_src_inc;
  logic        cmd_dst_inc;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_done;

  iomem_dma_if mem ();

  iomem_dma #(.LEN_BITS(16), .TIMEOUT(64)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_len     (cmd_len),
    .cmd_src_inc (cmd_src_inc),
    .cmd_dst_inc (cmd_dst_inc),
    .mem         (mem.master),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_done  (words_done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // responder state
  int          lat_default = 1;
  int          stall_idx   = -1;
  int          stall_lat   = 1;
  int          txn_idx     = 0;
  int          cnt         = 0;
  int          gap         = 0;
  int          stab_err    = 0;
  logic [31:0] a0;
  logic [3:0]  w0;
  logic [31:0] rd_q[$];
  logic [31:0] log_addr[$];
  logic [3:0]  log_wstrb[$];
  logic [31:0] log_wdata[$];
  int          log_gap[$];

  // ready is driven on the falling edge so the DUT samples a settled value
  always @(negedge clk) begin
    int lat;
    if (mem.mem_ready) begin
      mem.mem_ready = 1'b0;
      cnt = 0;
      gap = 0;
    end
    if (!mem.mem_valid) begin
      cnt = 0;
      gap++;
    end else begin
      if (cnt == 0) begin
        a0 = mem.mem_addr;
        w0 = mem.mem_wstrb;
        log_gap.push_back(gap);
      end else if (mem.mem_addr !== a0 || mem.mem_wstrb !== w0) begin
        stab_err++;
      end
      lat = (txn_idx == stall_idx) ? stall_lat : lat_default;
      if (cnt >= lat) begin
        mem.mem_ready = 1'b1;
        if (mem.mem_wstrb == 4'h0)
          mem.mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        log_addr.push_back(mem.mem_addr);
        log_wstrb.push_back(mem.mem_wstrb);
        log_wdata.push_back(mem.mem_wdata);
        txn_idx++;
      end
      cnt++;
    end
  end

  task automatic clr();
    rd_q.delete();
    log_addr.delete();
    log_wstrb.delete();
    log_wdata.delete();
    log_gap.delete();
    txn_idx   = 0;
    stall_idx = -1;
    stab_err  = 0;
  endtask

  task automatic start_cmd(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic si,
                           input logic di);
    @(negedge clk);
    nvec++;
    if (cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL cmd_ready_before_accept got=%b exp=1", cmd_ready);
    end
    cmd_src     = s;
    cmd_dst     = d;
    cmd_len     = n;
    cmd_src_inc = si;
    cmd_dst_inc = di;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int wr_hi);
    cyc   = 1;
    wr_hi = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (mem.mem_valid && mem.mem_wstrb == 4'hF) wr_hi++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 3000) begin
      nerr++;
      $display("FAIL done_wait expired after %0d cycles", cyc);
    end
  endtask

  task automatic check_idle_after();
    @(posedge clk);
    #1;
    nvec++;
    if ({busy, done, cmd_ready} !== 3'b001) begin
      nerr++;
      $display("FAIL idle_after_done busy/done/rdy=%b exp=001",
               {busy, done, cmd_ready});
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_src_inc = 1'b0;
    cmd_dst_inc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({cmd_ready, busy, done, error} !== 4'b1000) begin
      nerr++;
      $display("FAIL reset_flags rdy/busy/done/err=%b exp=1000",
               {cmd_ready, busy, done, error});
    end
    nvec++;
    if ({mem.mem_valid, mem.mem_wstrb} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_bus valid/wstrb=%b exp=00000",
               {mem.mem_valid, mem.mem_wstrb});
    end
    nvec++;
    if (mem.mem_addr !== 32'h0 || mem.mem_wdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_addr_data addr=%h wdata=%h exp=0",
               mem.mem_addr, mem.mem_wdata);
    end
    nvec++;
    if (words_done !== 16'd0) begin
      nerr++;
      $display("FAIL reset_words got=%0d exp=0", words_done);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single();
    int cyc, wh;
    clr();
    rd_q.push_back(32'hDEAD_BEEF);
    start_cmd(32'h0300_1000, 32'h0300_2000, 16'd1, 1'b1, 1'b1);
    wait_done(cyc, wh);
    nvec++;
    if (cyc !== 7) begin
      nerr++;
      $display("FAIL single_done_cycle got=%0d exp=7", cyc);
    end
    nvec++;
    if (words_done !== 16'd1 || error !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL single_status words=%0d err=%b busy=%b exp=1/0/1",
               words_done, error, busy);
    end
    nvec++;
    if (log_addr.size() !== 2) begin
      nerr++;
      $display("FAIL single_txn_count got=%0d exp=2", log_addr.size());
    end else begin
      nvec++;
      if (log_addr[0] !== 32'h0300_1000 || log_wstrb[0] !== 4'h0) begin
        nerr++;
        $display("FAIL single_read addr=%h wstrb=%h exp=03001000/0",
                 log_addr[0], log_wstrb[0]);
      end
      nvec++;
      if (log_addr[1] !== 32'h0300_2000 || log_wstrb[1] !== 4'hF ||
          log_wdata[1] !== 32'hDEAD_BEEF) begin
        nerr++;
        $display("FAIL single_write addr=%h wstrb=%h wdata=%h exp=03002000/f/deadbeef",
                 log_addr[1], log_wstrb[1], log_wdata[1]);
      end
    end
    check_idle_after();
  endtask

  task automatic test_fifo_src();
    int cyc, wh;
    clr();
    for (int i = 1; i <= 4; i++) rd_q.push_back(32'(i));
    start_cmd(32'h0300_1002, 32'h0300_2000, 16'd4, 1'b0, 1'b1);
    wait_done(cyc, wh);
    nvec++;
    if (cyc !== 25) begin
      nerr++;
      $display("FAIL fifo_done_cycle got=%0d exp=25", cyc);
    end
    nvec++;
    if (log_addr.size() !== 8) begin
      nerr++;
      $display("FAIL fifo_txn_count got=%0d exp=8", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (log_addr[2*i] !== 32'h0300_1000 ||
            log_wstrb[2*i] !== 4'h0) begin
          nerr++;
          $display("FAIL fifo_read%0d addr=%h wstrb=%h exp=03001000/0",
                   i, log_addr[2*i], log_wstrb[2*i]);
        end
        nvec++;
        if (log_addr[2*i+1] !== 32'h0300_2000 + 32'(4*i) ||
            log_wdata[2*i+1] !== 32'(i+1)) begin
          nerr++;
          $display("FAIL fifo_write%0d addr=%h wdata=%h exp=%h/%h", i,
                   log_addr[2*i+1], log_wdata[2*i+1],
                   32'h0300_2000 + 32'(4*i), 32'(i+1));
        end
      end
      for (int i = 1; i < 8; i++) begin
        nvec++;
        if (log_gap[i] !== 1) begin
          nerr++;
          $display("FAIL fifo_gap%0d got=%0d exp=1", i, log_gap[i]);
        end
      end
    end
    nvec++;
    if (words_done !== 16'd4 || error !== 1'b0) begin
      nerr++;
      $display("FAIL fifo_status words=%0d err=%b exp=4/0",
               words_done, error);
    end
    check_idle_after();
  endtask

  task automatic test_stall();
    int cyc, wh;
    clr();
    stall_idx = 2;
    stall_lat = 11;
    rd_q.push_back(32'hA5A5_0001);
    rd_q.push_back(32'hA5A5_0002);
    start_cmd(32'h0300_1000, 32'h0300_2010, 16'd2, 1'b1, 1'b1);
    wait_done(cyc, wh);
    nvec++;
    if (cyc !== 23) begin
      nerr++;
      $display("FAIL stall_done_cycle got=%0d exp=23", cyc);
    end
    nvec++;
    if (stab_err !== 0) begin
      nerr++;
      $display("FAIL stall_stability changes=%0d exp=0", stab_err);
    end
    nvec++;
    if (log_addr.size() !== 4) begin
      nerr++;
      $display("FAIL stall_txn_count got=%0d exp=4", log_addr.size());
    end else begin
      nvec++;
      if (log_addr[2] !== 32'h0300_1004 || log_addr[3] !== 32'h0300_2014 ||
          log_wdata[3] !== 32'hA5A5_0002) begin
        nerr++;
        $display("FAIL stall_second raddr=%h waddr=%h wdata=%h exp=03001004/03002014/a5a50002",
                 log_addr[2], log_addr[3], log_wdata[3]);
      end
    end
    check_idle_after();
  endtask

  task automatic test_timeout();
    int cyc, wh;
    clr();
    stall_idx = 1;
    stall_lat = 100000;
    rd_q.push_back(32'h1234_5678);
    start_cmd(32'h0300_1000, 32'h0300_2000, 16'd1, 1'b1, 1'b1);
    wait_done(cyc, wh);
    nvec++;
    if (wh !== 64) begin
      nerr++;
      $display("FAIL timeout_valid_cycles got=%0d exp=64", wh);
    end
    nvec++;
    if (cyc !== 68) begin
      nerr++;
      $display("FAIL timeout_done_cycle got=%0d exp=68", cyc);
    end
    nvec++;
    if (error !== 1'b1 || words_done !== 16'd0 || mem.mem_valid !== 1'b0) begin
      nerr++;
      $display("FAIL timeout_status err=%b words=%0d valid=%b exp=1/0/0",
               error, words_done, mem.mem_valid);
    end
    check_idle_after();
    nvec++;
    if (error !== 1'b1) begin
      nerr++;
      $display("FAIL timeout_error_held got=%b exp=1", error);
    end
  endtask

  task automatic test_wrap();
    int cyc, wh;
    clr();
    rd_q.push_back(32'h0000_00AA);
    rd_q.push_back(32'h0000_00BB);
    start_cmd(32'h0300_1000, 32'hFFFF_FFFC, 16'd2, 1'b0, 1'b1);
    nvec++;
    if (error !== 1'b0) begin
      nerr++;
      $display("FAIL wrap_error_cleared got=%b exp=0", error);
    end
    wait_done(cyc, wh);
    nvec++;
    if (log_addr.size() !== 4) begin
      nerr++;
      $display("FAIL wrap_txn_count got=%0d exp=4", log_addr.size());
    end else begin
      nvec++;
      if (log_addr[1] !== 32'hFFFF_FFFC || log_addr[3] !== 32'h0000_0000) begin
        nerr++;
        $display("FAIL wrap_addrs w0=%h w1=%h exp=fffffffc/00000000",
                 log_addr[1], log_addr[3]);
      end
    end
    check_idle_after();
  endtask

  task automatic test_len0();
    int cyc, wh;
    clr();
    start_cmd(32'h0300_1000, 32'h0300_2000, 16'd0, 1'b1, 1'b1);
    wait_done(cyc, wh);
    nvec++;
    if (cyc !== 1) begin
      nerr++;
      $display("FAIL len0_done_cycle got=%0d exp=1", cyc);
    end
    check_idle_after();
    repeat (3) @(posedge clk);
    nvec++;
    if (log_gap.size() !== 0 || words_done !== 16'd0) begin
      nerr++;
      $display("FAIL len0_no_bus txns=%0d words=%0d exp=0/0",
               log_gap.size(), words_done);
    end
  endtask

  task automatic test_reset_mid_wr();
    int n;
    clr();
    for (int i = 0; i < 4; i++) rd_q.push_back(32'hC0DE_0000 + 32'(i));
    start_cmd(32'h0300_1000, 32'h0300_2000, 16'd4, 1'b1, 1'b1);
    n = 0;
    while (!(mem.mem_valid && mem.mem_wstrb == 4'hF) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    nvec++;
    if (n >= 100) begin
      nerr++;
      $display("FAIL rst_mid_wait write_valid absent after %0d cycles", n);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    nvec++;
    if ({mem.mem_valid, busy, cmd_ready} !== 3'b001) begin
      nerr++;
      $display("FAIL rst_mid_state valid/busy/rdy=%b exp=001",
               {mem.mem_valid, busy, cmd_ready});
    end
    nvec++;
    if (words_done !== 16'd0) begin
      nerr++;
      $display("FAIL rst_mid_words got=%0d exp=0", words_done);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    mem.mem_ready = 1'b0;
    mem.mem_rdata = 32'h0;
    test_reset();
    test_single();
    test_fifo_src();
    test_stall();
    test_timeout();
    test_wrap();
    test_len0();
    test_reset_mid_wr();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
